ysyx_22051086_div_responder: RTL and testbench
==============================================

Name: ysyx_22051086_div_responder

Overview:
- Multi-cycle radix-2 restoring integer divider; the responder side of the EX-stage ALU divide valid/ready handshake.
- Serves RV64M div/divu/rem/remu and divw/divuw/remw/remuw.
- Accepts one request at a time, iterates one quotient bit per cycle, then pulses out_valid once.
- Holds quotient/remainder stable until the next accepted request.

Parameters:
XLEN, 64, operand/result width; word ops use the low XLEN/2 bits.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
dividend  input  XLEN  dividend operand, sampled on accept
divisor  input  XLEN  divisor operand, sampled on accept
div_valid  input  1  request strobe
divw  input  1  word operation (32-bit operands, sign-extended results), sampled on accept
div_signed  input  1  signed operation, sampled on accept
flush  input  1  abort any in-flight operation
div_ready  output  1  high iff state is IDLE
out_valid  output  1  one-cycle result pulse
quotient  output  XLEN  quotient result, registered
remainder  output  XLEN  remainder result, registered

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; out_valid=0; quotient=0; remainder=0; iteration counter=0.
  - div_ready=1 while in reset and after release.
- States IDLE, CALC, DONE.
- Accept: div_valid && div_ready && !flush in IDLE. Inputs are not sampled in any other cycle.
- Operand prep on accept:
  - Word op: use bits [31:0] only, N=32; otherwise N=XLEN.
  - Signed: latch magnitudes |a|, |b| and the sign flags sa, sb.
  - Unsigned: magnitudes are the raw bits.
- Special cases, resolved at accept (IDLE->DONE, no CALC):
  - Divisor (within N bits) == 0: q = all ones (N bits), r = dividend (N bits).
  - Signed overflow (dividend = most-negative N-bit value, divisor = -1): q = dividend, r = 0.
- Normal path, IDLE->CALC, counter=N. Each CALC cycle:
  - partial remainder = {rem, next dividend bit}.
  - If partial >= divisor magnitude: subtract and shift in quotient bit 1; else shift in 0.
  - counter decrements. When the counter reaches 0 in this step, go to DONE.
- Result fix-up, registered on entry to DONE:
  - Quotient negated iff signed && (sa ^ sb).
  - Remainder negated iff signed && sa (remainder takes the dividend's sign).
  - Word ops: the 32-bit results are sign-extended from bit 31 to XLEN, for both signed and unsigned variants.
- DONE: out_valid=1 for exactly one cycle, then unconditionally return to IDLE.
- Latency, with accept in cycle T:
  - out_valid in cycle T+N+1 (T+65 for 64-bit, T+33 for word ops).
  - out_valid in cycle T+1 for special cases.
  - div_ready is low from T+1 through the DONE cycle and high again the cycle after out_valid.
- quotient/remainder change only on entry to DONE and otherwise hold their last value, including after flush.
- flush:
  - In CALC or DONE: next state IDLE, out_valid forced 0 in that cycle and the next, result registers untouched.
  - In IDLE: suppresses acceptance in that cycle.
- div_valid while busy: ignored. The requester must hold the request until it sees div_ready.
- Reset asserted mid-operation: immediate return to reset values. No out_valid is produced for the aborted operation.

Test Plan:
- Signed 64-bit: dividend=0xFFFF_FFFF_FFFF_FFF9 (-7), divisor=2 -> at T+65: quotient=0xFFFF_FFFF_FFFF_FFFD (-3), remainder=0xFFFF_FFFF_FFFF_FFFF (-1), out_valid high for exactly 1 cycle.
- Unsigned word: divw=1, div_signed=0, dividend=0x1234_5678_FFFF_FFFE, divisor=1 -> at T+33: quotient=0xFFFF_FFFF_FFFF_FFFE (sign-extended), remainder=0.
- Also unsigned word: low dividend 0x8000_0000, divisor=3 -> quotient=0x2AAA_AAAA, remainder=2.
- Divide by zero: signed, dividend=42, divisor=0 -> at T+1: quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=42.
- Word divide by zero: dividend low=0x0000_0005, divisor low=0 -> quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=5.
- Overflow: signed 64-bit 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> at T+1: quotient=0x8000_0000_0000_0000, remainder=0.
- Overflow, word: 0x8000_0000 / 0xFFFF_FFFF -> quotient=0xFFFF_FFFF_8000_0000, remainder=0.
- Flush at T+10 of a 64-bit op -> no out_valid ever for that op; div_ready=1 at T+11; outputs retain prior values.
- Immediate re-issue after that flush: 100/7 unsigned -> quotient=14, remainder=2 at accept+65.
- rst pulled low asynchronously mid-CALC -> outputs 0 and div_ready=1 without waiting for a clock edge; no stray out_valid after release.
- Back-to-back: div_valid held high continuously -> second op accepted exactly on the cycle after the first out_valid.

Source files
------------

// File: rtl/ysyx_22051086_div_responder_if.sv
// Divide request/response bundle between the EX-stage ALU (requester) and
// the multi-cycle divider (responder).
//   master : requester side; drives operands, div_valid, divw, div_signed, flush
//   slave  : divider side; drives div_ready, out_valid, quotient, remainder
interface ysyx_22051086_div_responder_if #(
  parameter int XLEN = 64
);
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            div_valid;
  logic            divw;
  logic            div_signed;
  logic            flush;
  logic            div_ready;
  logic            out_valid;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  modport master (
    output dividend, divisor, div_valid, divw, div_signed, flush,
    input  div_ready, out_valid, quotient, remainder
  );

  modport slave (
    input  dividend, divisor, div_valid, divw, div_signed, flush,
    output div_ready, out_valid, quotient, remainder
  );
endinterface

// File: rtl/ysyx_22051086_div_responder.sv
// Multi-cycle radix-2 restoring divider for RV64M div/divu/rem/remu and the
// word variants. One request at a time; one quotient bit per cycle; a single
// out_valid pulse; quotient/remainder hold until the next result is produced.
// Ports:
//   clk : clock, all state on rising edge
//   rst : asynchronous active-low reset
//   bus : slave side of the divide handshake interface
module ysyx_22051086_div_responder #(
  parameter int XLEN = 64
) (
  input logic                            clk,
  input logic                            rst,
  ysyx_22051086_div_responder_if.slave   bus
);

  localparam int HALF  = XLEN / 2;
  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_WORD = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             out_valid_q;
  logic [XLEN-1:0]  quotient_q;
  logic [XLEN-1:0]  remainder_q;

  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  dvd_q;
  logic [XLEN-1:0]  dsr_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic             word_q;

  function automatic logic [XLEN-1:0] sext_half(input logic [HALF-1:0] x);
    return {{HALF{x[HALF-1]}}, x};
  endfunction

  function automatic logic [XLEN-1:0] zext_half(input logic [HALF-1:0] x);
    return {{HALF{1'b0}}, x};
  endfunction

  function automatic logic [XLEN-1:0] abs_mag(input logic signed [XLEN-1:0] x,
                                              input logic neg);
    logic [XLEN-1:0] u;
    u = x;
    return neg ? (~u + 1'b1) : u;
  endfunction

  // Apply the result sign, then sign-extend word results from bit 31.
  function automatic logic [XLEN-1:0] fix_result(input logic [XLEN-1:0] mag,
                                                 input logic neg,
                                                 input logic word);
    logic signed [XLEN-1:0] v;
    v = neg ? -$signed(mag) : $signed(mag);
    return word ? sext_half(v[HALF-1:0]) : v;
  endfunction

  // Operand preparation, only meaningful in the accept cycle.
  logic signed [XLEN-1:0] a_ext, b_ext;
  logic                   sa_in, sb_in;
  logic [XLEN-1:0]        a_mag, b_mag;
  logic                   accept, div_zero, overflow;

  always_comb begin
    if (bus.divw) begin
      a_ext = bus.div_signed ? sext_half(bus.dividend[HALF-1:0]) : zext_half(bus.dividend[HALF-1:0]);
      b_ext = bus.div_signed ? sext_half(bus.divisor[HALF-1:0])  : zext_half(bus.divisor[HALF-1:0]);
    end else begin
      a_ext = bus.dividend;
      b_ext = bus.divisor;
    end
    sa_in    = bus.div_signed & a_ext[XLEN-1];
    sb_in    = bus.div_signed & b_ext[XLEN-1];
    a_mag    = abs_mag(a_ext, sa_in);
    b_mag    = abs_mag(b_ext, sb_in);
    accept   = (state == IDLE) && bus.div_valid && !bus.flush;
    div_zero = (b_ext == '0);
    // Unsigned word divisors are zero-extended, so &b_ext only hits for signed ops.
    overflow = bus.div_signed && (&b_ext) &&
               (a_ext == (bus.divw ? MIN_WORD : MIN_FULL));
  end

  // One restoring step. The partial remainder is XLEN+1 bits wide; its top
  // bit set means it certainly exceeds the divisor, and the true difference
  // still fits in XLEN bits.
  logic [XLEN-1:0] partial_lo;
  logic            ge;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;

  always_comb begin
    partial_lo = {rem_q[XLEN-2:0], dvd_q[XLEN-1]};
    ge         = rem_q[XLEN-1] || (partial_lo >= dsr_q);
    rem_nxt    = ge ? (partial_lo - dsr_q) : partial_lo;
    quo_nxt    = {quo_q[XLEN-2:0], ge};
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (div_zero) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= bus.divw ? sext_half(bus.dividend[HALF-1:0]) : bus.dividend;
            end else if (overflow) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              quotient_q  <= a_ext;
              remainder_q <= '0;
            end else begin
              state <= CALC;
              cnt   <= bus.divw ? CNT_W'(HALF) : CNT_W'(XLEN);
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              quotient_q  <= fix_result(quo_nxt, neg_q_q, word_q);
              remainder_q <= fix_result(rem_nxt, neg_r_q, word_q);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Working datapath; loaded on accept, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      // Word dividends are left-aligned so bits always leave from the MSB.
      dvd_q   <= bus.divw ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
      dsr_q   <= b_mag;
      rem_q   <= '0;
      quo_q   <= '0;
      neg_q_q <= sa_in ^ sb_in;
      neg_r_q <= sa_in;
      word_q  <= bus.divw;
    end else if (state == CALC) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      dvd_q <= {dvd_q[XLEN-2:0], 1'b0};
    end
  end

  assign bus.div_ready = (state == IDLE);
  // A flush landing on the DONE cycle kills the pulse that is already up.
  assign bus.out_valid = out_valid_q && !bus.flush;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;

endmodule

// File: tb/tb_ysyx_22051086_div_responder.sv
module tb_ysyx_22051086_div_responder;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  ysyx_22051086_div_responder_if #(.XLEN(XLEN)) bus ();

  ysyx_22051086_div_responder #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request while idle, wait for the pulse, check latency, results,
  // pulse width and return to idle.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic w, input logic s, input int exp_lat,
                        input logic [63:0] eq, input logic [63:0] er);
    int lat;
    check({tag, ":ready_before"}, bus.div_ready, 1);
    bus.dividend   = a;
    bus.divisor    = b;
    bus.divw       = w;
    bus.div_signed = s;
    bus.div_valid  = 1'b1;
    step();
    bus.div_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    check({tag, ":latency"}, lat, exp_lat);
    check({tag, ":quotient"}, bus.quotient, eq);
    check({tag, ":remainder"}, bus.remainder, er);
    step();
    check({tag, ":pulse_width"}, bus.out_valid, 0);
    check({tag, ":ready_after"}, bus.div_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovs;
    int lat;
    rst            = 1'b1;
    bus.dividend   = '0;
    bus.divisor    = '0;
    bus.div_valid  = 1'b0;
    bus.divw       = 1'b0;
    bus.div_signed = 1'b0;
    bus.flush      = 1'b0;

    // Reset values, visible before any clock edge.
    #2 rst = 1'b0;
    #1;
    check("rst:ready", bus.div_ready, 1);
    check("rst:out_valid", bus.out_valid, 0);
    check("rst:quotient", bus.quotient, 0);
    check("rst:remainder", bus.remainder, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    step();
    check("post_rst:ready", bus.div_ready, 1);

    run_op("s64_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b1, 65,
           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("s64_100_m7", 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b1, 65,
           64'hFFFF_FFFF_FFFF_FFF2, 64'd2);
    run_op("uw_fffe_1", 64'h1234_5678_FFFF_FFFE, 64'd1, 1'b1, 1'b0, 33,
           64'hFFFF_FFFF_FFFF_FFFE, 64'd0);
    run_op("uw_8000_3", 64'h0000_0000_8000_0000, 64'd3, 1'b1, 1'b0, 33,
           64'h0000_0000_2AAA_AAAA, 64'd2);
    run_op("s64_divzero", 64'd42, 64'd0, 1'b0, 1'b1, 1,
           64'hFFFF_FFFF_FFFF_FFFF, 64'd42);
    run_op("w_divzero", 64'h0000_0000_0000_0005, 64'd0, 1'b1, 1'b0, 1,
           64'hFFFF_FFFF_FFFF_FFFF, 64'd5);
    run_op("s64_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1,
           64'h8000_0000_0000_0000, 64'd0);
    run_op("sw_ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 1,
           64'hFFFF_FFFF_8000_0000, 64'd0);

    // Flush in cycle T+10 of a 64-bit op.
    bus.dividend   = 64'd1000;
    bus.divisor    = 64'd3;
    bus.divw       = 1'b0;
    bus.div_signed = 1'b0;
    bus.div_valid  = 1'b1;
    step();
    bus.div_valid = 1'b0;
    check("flush:busy", bus.div_ready, 0);
    ovs = 0;
    for (int i = 0; i < 9; i++) begin
      if (bus.out_valid === 1'b1) ovs++;
      step();
    end
    bus.flush = 1'b1;
    if (bus.out_valid === 1'b1) ovs++;
    step();
    bus.flush = 1'b0;
    check("flush:no_pulse", ovs, 0);
    check("flush:ready_T11", bus.div_ready, 1);
    check("flush:out_valid_T11", bus.out_valid, 0);
    check("flush:quotient_kept", bus.quotient, 64'hFFFF_FFFF_8000_0000);
    check("flush:remainder_kept", bus.remainder, 64'd0);
    run_op("reissue_100_7", 64'd100, 64'd7, 1'b0, 1'b0, 65, 64'd14, 64'd2);

    // Asynchronous reset in the middle of CALC, asserted between clock edges.
    bus.dividend  = 64'd1000;
    bus.divisor   = 64'd3;
    bus.div_valid = 1'b1;
    step();
    bus.div_valid = 1'b0;
    repeat (5) step();
    #3 rst = 1'b0;
    #1;
    check("arst:ready", bus.div_ready, 1);
    check("arst:out_valid", bus.out_valid, 0);
    check("arst:quotient", bus.quotient, 0);
    check("arst:remainder", bus.remainder, 0);
    step();
    step();
    #2 rst = 1'b1;
    ovs = 0;
    for (int i = 0; i < 70; i++) begin
      step();
      if (bus.out_valid === 1'b1) ovs++;
    end
    check("arst:no_stray_pulse", ovs, 0);
    check("arst:quotient_held", bus.quotient, 0);

    // Back-to-back with div_valid held high throughout.
    bus.dividend   = 64'd20;
    bus.divisor    = 64'd6;
    bus.divw       = 1'b0;
    bus.div_signed = 1'b0;
    bus.div_valid  = 1'b1;
    step();
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    check("b2b1:latency", lat, 65);
    check("b2b1:quotient", bus.quotient, 64'd3);
    check("b2b1:remainder", bus.remainder, 64'd2);
    bus.dividend = 64'd50;
    bus.divisor  = 64'd7;
    bus.divw     = 1'b1;
    step();
    check("b2b2:ready_at_accept", bus.div_ready, 1);
    step();
    check("b2b2:busy_after_accept", bus.div_ready, 0);
    bus.div_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    check("b2b2:latency", lat, 33);
    check("b2b2:quotient", bus.quotient, 64'd7);
    check("b2b2:remainder", bus.remainder, 64'd1);
    step();
    check("b2b2:pulse_width", bus.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
